disp_sad_engine: RTL
====================

# disp_sad_engine

Parametrised stereo block-matching core: for each pixel of a row, computes the window sum of absolute differences (SAD) between the reference frame and NUM_DISP leftward-shifted candidates from the search frame, both read from row-circular BRAMs, and emits the best disparity. It is the successor to the fixed 7x7/64-disparity calculator, with row-granular start, a stall input, a valid/ready output stream and configurable widths. It sits between the row-loading BRAM fillers and the disparity packer/FIFO writer.

## Interface
- PIX_W, 12: pixel bits used from BRAM data
- DATA_W, 16: BRAM data width; pixel is bits [PIX_W-1:0]
- WIN, 7: odd window size; H = WIN/2
- NUM_DISP, 64: disparities searched, 0..NUM_DISP-1
- DISP_W, 7: disparity output width; requires NUM_DISP < 2**DISP_W
- SAD_W, 18: accumulator width; requires SAD_W >= PIX_W + ceil(log2(WIN*WIN))
- HRES, 640 / VRES, 480: frame size
- ROWS_IN_BRAM, 8: rows held per BRAM (circular)
- ADDR_W, 13: BRAM address width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- row_go  in  1  start one row (sampled in IDLE only)
- busy  in  1  BRAM owner busy; stalls read issue
- en_ref, en_search  out  1  BRAM read enables (driven together)
- addr_ref, addr_search  out  ADDR_W  read addresses
- dout_ref, dout_search  in  DATA_W  read data, valid 1 cycle after enable
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_disp  out  DISP_W  best disparity
- out_sad  out  SAD_W  best SAD
- out_invalid  out  1  threshold reject flag (see Configuration)
- row_done  out  1  one-cycle pulse, row finished
- frame_done  out  1  one-cycle pulse with row_done on last row

## Operation
- Processed pixels: rows r = H..VRES-1-H, columns c = H+NUM_DISP-1..HRES-1-H. Internal r and c reset to first row/column.
- Tap (wr, wc) in 0..WIN-1: addr_ref = ((r-H+wr) mod ROWS_IN_BRAM)*HRES + (c-H+wc); addr_search = addr_ref - d.
- Issue order per pixel: d outer 0..NUM_DISP-1, taps raster (wc inner). One tap per non-stalled cycle.
- Data returning one cycle after issue: |ref - search| on PIX_W bits, unsigned, added to acc. First tap of each d loads acc instead of adding.
- On last tap of d: if final SAD < best_sad (strict), best_sad/best_d update. Ties keep lowest d. best_sad resets to all-ones per pixel.
- States: IDLE (wait row_go) -> ISSUE (reads) -> DRAIN (1 cycle, last data accumulated/compared) -> OUT (out_valid=1 until out_ready) -> ISSUE for next column, or IDLE at row end.
- Row end: row_done pulses the cycle after the final OUT handshake; r increments. After row VRES-1-H, frame_done pulses too and r wraps to H.
- busy high in ISSUE: en low, tap/d counters hold; the read already in flight is still accumulated. busy ignored in IDLE, DRAIN and OUT.
- row_go outside IDLE is ignored.

## Timing
- Reset (async): state IDLE; all outputs 0; r=H, c=first column, counters 0, best_sad all-ones.
- Reset mid-row aborts; no pulses; next row_go restarts at row H.
- Unstalled latency per pixel: NUM_DISP*WIN*WIN issue cycles + 1 DRAIN + 1 OUT (out_ready high) cycles.
- out_disp/out_sad/out_invalid are stable while out_valid && !out_ready. No reads are issued in OUT.
- en_ref and en_search assert in the same cycle as their address.

## Configuration
- DISP_SAD_THRESH_EN defined: adds input sad_thresh [SAD_W-1:0]. If best_sad > sad_thresh, out_invalid=1 and out_disp = all-ones. out_sad stays valid.
- Undefined: no sad_thresh port; out_invalid tied 0.

## Test plan
Bench parameters: WIN=3, NUM_DISP=4, HRES=16, VRES=8, ROWS_IN_BRAM=4, PIX_W=12, SAD_W=16, DISP_W=3. This gives 11 pixels/row, rows 1..6 and 38 cycles/pixel.
- Identical ref and search, ref[y][x] = (x*37+y*11) mod 4096 -> every out_disp=0, out_sad=0; row_done after 11 outputs; 418 cycles row_go->row_done.
- search[y][x] = ref[y][x+2], same texture -> every out_disp=2, out_sad=0.
- Flat images, all 100 -> all SAD 0, tie -> out_disp=0.
- out_ready low 20 cycles on first result -> out_valid held, data stable, en_ref/en_search low throughout. Remaining outputs are unchanged.
- busy high 5 cycles mid-window -> outputs identical to the unstalled run; row completes exactly 5 cycles later.
- 6 row_go pulses -> 6 row_done; frame_done only with 6th; 7th row_go reads rows 0..2 addresses again. Async reset asserted mid-row clears all outputs at once.
- With DISP_SAD_THRESH_EN, ref=0, search=4095, sad_thresh=1000 -> out_sad=36855, out_invalid=1, out_disp=7. Without the macro -> out_invalid=0, out_disp=0.

Source files
------------

// File: rtl/disp_sad_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disp_sad_engine                                                          |
// | Stereo block-matching core: windowed SAD over NUM_DISP candidates per    |
// | pixel of a row, best disparity out on a valid/ready stream.              |
// | Optional: DISP_SAD_THRESH_EN adds sad_thresh and the reject flag.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module disp_sad_engine #(
  parameter int PIX_W        = 12,
  parameter int DATA_W       = 16,
  parameter int WIN          = 7,
  parameter int NUM_DISP     = 64,
  parameter int DISP_W       = 7,
  parameter int SAD_W        = 18,
  parameter int HRES         = 640,
  parameter int VRES         = 480,
  parameter int ROWS_IN_BRAM = 8,
  parameter int ADDR_W       = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              row_go,
  input  logic              busy,
  output logic              en_ref,
  output logic              en_search,
  output logic [ADDR_W-1:0] addr_ref,
  output logic [ADDR_W-1:0] addr_search,
  input  logic [DATA_W-1:0] dout_ref,
  input  logic [DATA_W-1:0] dout_search,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DISP_W-1:0] out_disp,
  output logic [SAD_W-1:0]  out_sad,
  output logic              out_invalid,
  output logic              row_done,
  output logic              frame_done
`ifdef DISP_SAD_THRESH_EN
  ,
  input  logic [SAD_W-1:0]  sad_thresh
`endif
);

  localparam int c_H     = WIN / 2;
  localparam int c_ROW_W = $clog2(VRES);
  localparam int c_COL_W = $clog2(HRES);
  localparam int c_TAP_W = (WIN > 1) ? $clog2(WIN) : 1;

  localparam logic [c_ROW_W-1:0] c_ROW_FIRST = c_ROW_W'(c_H);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST  = c_ROW_W'(VRES - 1 - c_H);
  localparam logic [c_COL_W-1:0] c_COL_FIRST = c_COL_W'(c_H + NUM_DISP - 1);
  localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(HRES - 1 - c_H);
  localparam logic [c_TAP_W-1:0] c_TAP_LAST  = c_TAP_W'(WIN - 1);
  localparam logic [DISP_W-1:0]  c_D_LAST    = DISP_W'(NUM_DISP - 1);
  localparam logic [SAD_W-1:0]   c_SAD_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t              r_state;
  logic [c_ROW_W-1:0]  r_row;
  logic [c_COL_W-1:0]  r_col;
  logic [c_TAP_W-1:0]  r_wr;
  logic [c_TAP_W-1:0]  r_wc;
  logic [DISP_W-1:0]   r_d;
  logic                r_v;
  logic                r_first;
  logic                r_last;
  logic [DISP_W-1:0]   r_dp;
  logic [SAD_W-1:0]    r_acc;
  logic [SAD_W-1:0]    r_best_sad;
  logic [DISP_W-1:0]   r_best_d;
  logic                r_out_valid;
  logic [DISP_W-1:0]   r_out_disp;
  logic [SAD_W-1:0]    r_out_sad;
  logic                r_out_invalid;
  logic                r_row_done;
  logic                r_frame_done;

  logic                w_issue;
  logic [ADDR_W-1:0]   w_brow;
  logic [ADDR_W-1:0]   w_addr_ref;
  logic [PIX_W-1:0]    w_pr;
  logic [PIX_W-1:0]    w_ps;
  logic [PIX_W-1:0]    w_diff;
  logic [SAD_W-1:0]    w_cand;
  logic                w_upd;
  logic [SAD_W-1:0]    w_best_sad;
  logic [DISP_W-1:0]   w_best_d;
  logic                w_reject;

  assign w_issue   = (r_state == S_ISSUE) && !busy;
  assign en_ref    = w_issue;
  assign en_search = w_issue;

  // Window row is mapped onto the circular BRAM slot; column offset is linear.
  always_comb begin
    w_brow     = (ADDR_W'(r_row) + ADDR_W'(r_wr) - ADDR_W'(c_H)) % ADDR_W'(ROWS_IN_BRAM);
    w_addr_ref = w_brow * ADDR_W'(HRES) + ADDR_W'(r_col) + ADDR_W'(r_wc) - ADDR_W'(c_H);
  end

  assign addr_ref    = (r_state == S_ISSUE) ? w_addr_ref : '0;
  assign addr_search = (r_state == S_ISSUE) ? (w_addr_ref - ADDR_W'(r_d)) : '0;

  assign w_pr = dout_ref[PIX_W-1:0];
  assign w_ps = dout_search[PIX_W-1:0];

  always_comb begin
    w_diff     = (w_pr >= w_ps) ? (w_pr - w_ps) : (w_ps - w_pr);
    w_cand     = r_first ? SAD_W'(w_diff) : (r_acc + SAD_W'(w_diff));
    w_upd      = r_v && r_last && (w_cand < r_best_sad);
    w_best_sad = w_upd ? w_cand : r_best_sad;
    w_best_d   = w_upd ? r_dp : r_best_d;
  end

`ifdef DISP_SAD_THRESH_EN
  assign w_reject = (w_best_sad > sad_thresh);
`else
  assign w_reject = 1'b0;
`endif

  generate
    if (DATA_W > PIX_W) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^{dout_ref[DATA_W-1:PIX_W], dout_search[DATA_W-1:PIX_W]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_row         <= c_ROW_FIRST;
      r_col         <= c_COL_FIRST;
      r_wr          <= '0;
      r_wc          <= '0;
      r_d           <= '0;
      r_v           <= 1'b0;
      r_first       <= 1'b0;
      r_last        <= 1'b0;
      r_dp          <= '0;
      r_acc         <= '0;
      r_best_sad    <= c_SAD_MAX;
      r_best_d      <= '0;
      r_out_valid   <= 1'b0;
      r_out_disp    <= '0;
      r_out_sad     <= '0;
      r_out_invalid <= 1'b0;
      r_row_done    <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_row_done   <= 1'b0;
      r_frame_done <= 1'b0;
      // Tap tags follow the read by one cycle, lining up with returning data.
      r_v          <= w_issue;
      if (w_issue) begin
        r_first <= (r_wr == '0) && (r_wc == '0);
        r_last  <= (r_wr == c_TAP_LAST) && (r_wc == c_TAP_LAST);
        r_dp    <= r_d;
      end
      if (r_v) begin
        r_acc <= w_cand;
      end
      r_best_sad <= w_best_sad;
      r_best_d   <= w_best_d;

      case (r_state)
        S_IDLE: begin
          if (row_go) begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!busy) begin
            if (r_wc != c_TAP_LAST) begin
              r_wc <= r_wc + 1'b1;
            end else begin
              r_wc <= '0;
              if (r_wr != c_TAP_LAST) begin
                r_wr <= r_wr + 1'b1;
              end else begin
                r_wr <= '0;
                if (r_d != c_D_LAST) begin
                  r_d <= r_d + 1'b1;
                end else begin
                  r_d     <= '0;
                  r_state <= S_DRAIN;
                end
              end
            end
          end
        end
        S_DRAIN: begin
          r_out_valid   <= 1'b1;
          r_out_sad     <= w_best_sad;
          r_out_invalid <= w_reject;
          r_out_disp    <= w_reject ? '1 : w_best_d;
          r_best_sad    <= c_SAD_MAX;
          r_best_d      <= '0;
          r_state       <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_col == c_COL_LAST) begin
              r_col      <= c_COL_FIRST;
              r_state    <= S_IDLE;
              r_row_done <= 1'b1;
              if (r_row == c_ROW_LAST) begin
                r_row        <= c_ROW_FIRST;
                r_frame_done <= 1'b1;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col   <= r_col + 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign out_disp    = r_out_disp;
  assign out_sad     = r_out_sad;
  assign out_invalid = r_out_invalid;
  assign row_done    = r_row_done;
  assign frame_done  = r_frame_done;

endmodule
`default_nettype wire
